// File: rtl/legv8_pkg.sv
// LEGv8 decode definitions: opcode prefixes, ALU operation encodings and
// the control bundle carried from decode into the ID/EX register.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0]  XZR     = 5'd31;

  typedef enum logic [3:0] {
    ALU_AND    = 4'b0000,
    ALU_ORR    = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_SUB    = 4'b0110,
    ALU_PASS_B = 4'b0111
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
    logic    uncond;
  } ctrl_t;

endpackage

// File: rtl/legv8_decoder.sv
// Combinational LEGv8 instruction decoder: control bundle, extended
// immediate and register-file source/destination fields.
module legv8_decoder
  import legv8_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [63:0] imm,
  output logic [4:0]  src1,
  output logic [4:0]  src2,
  output logic [4:0]  dst,
  output logic        uses_src2,
  output logic        illegal
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;

  assign op11 = instr[31:21];
  assign op10 = instr[31:22];
  assign op8  = instr[31:24];
  assign op6  = instr[31:26];

  assign src1 = instr[9:5];
  assign dst  = instr[4:0];

  always_comb begin
    ctrl      = '0;
    imm       = '0;
    src2      = instr[20:16];
    uses_src2 = 1'b0;
    illegal   = 1'b0;

    if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND || op11 == OP_ORR) begin
      uses_src2      = 1'b1;
      ctrl.reg_write = 1'b1;
      case (op11)
        OP_ADD:  ctrl.alu_op = ALU_ADD;
        OP_SUB:  ctrl.alu_op = ALU_SUB;
        OP_AND:  ctrl.alu_op = ALU_AND;
        default: ctrl.alu_op = ALU_ORR;
      endcase
    end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
      imm            = {52'd0, instr[21:10]};
      ctrl.alu_src   = 1'b1;
      ctrl.reg_write = 1'b1;
      ctrl.alu_op    = (op10 == OP_ADDI) ? ALU_ADD : ALU_SUB;
    end else if (op11 == OP_LDUR) begin
      imm             = {{55{instr[20]}}, instr[20:12]};
      ctrl.alu_src    = 1'b1;
      ctrl.mem_read   = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.reg_write  = 1'b1;
      ctrl.alu_op     = ALU_ADD;
    end else if (op11 == OP_STUR) begin
      // Store data register (Rt) is read through the second port.
      imm            = {{55{instr[20]}}, instr[20:12]};
      src2           = instr[4:0];
      uses_src2      = 1'b1;
      ctrl.alu_src   = 1'b1;
      ctrl.mem_write = 1'b1;
      ctrl.alu_op    = ALU_ADD;
    end else if (op8 == OP_CBZ) begin
      imm         = {{45{instr[23]}}, instr[23:5]};
      src2        = instr[4:0];
      uses_src2   = 1'b1;
      ctrl.branch = 1'b1;
      ctrl.alu_op = ALU_PASS_B;
    end else if (op6 == OP_B) begin
      imm         = {{38{instr[25]}}, instr[25:0]};
      ctrl.uncond = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// LEGv8 decode stage and ID/EX pipeline register with load-use hazard
// detection (one-cycle fetch stall) and a saturating stall-cycle counter.
module id_ex_stage
  import legv8_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [63:0] if_pc,
  input  logic        flush,
  output logic [4:0]  rf_add1,
  output logic [4:0]  rf_add2,
  input  logic [63:0] rf_read_1,
  input  logic [63:0] rf_read_2,
  output logic        stall_out,
  output logic        ex_valid,
  output logic [63:0] ex_pc,
  output logic [63:0] ex_op1,
  output logic [63:0] ex_op2,
  output logic [63:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rn,
  output logic [4:0]  ex_rm,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        ex_branch,
  output logic        ex_uncond,
  output logic        ex_illegal,
  output logic [31:0] stall_count
);

  ctrl_t       dec_ctrl;
  logic [63:0] dec_imm;
  logic [4:0]  dec_src1;
  logic [4:0]  dec_src2;
  logic [4:0]  dec_dst;
  logic        dec_uses_src2;
  logic        dec_illegal;

  ctrl_t       ex_ctrl;
  logic        hazard;
  logic        issue;

  legv8_decoder u_decoder (
    .instr     (if_instr),
    .ctrl      (dec_ctrl),
    .imm       (dec_imm),
    .src1      (dec_src1),
    .src2      (dec_src2),
    .dst       (dec_dst),
    .uses_src2 (dec_uses_src2),
    .illegal   (dec_illegal)
  );

  assign rf_add1 = dec_src1;
  assign rf_add2 = dec_src2;

  assign hazard = if_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != XZR) &
                  ((ex_rd == dec_src1) | (dec_uses_src2 & (ex_rd == dec_src2)));

  // Flush outranks the hazard: the younger instruction is being killed anyway.
  assign stall_out = hazard & ~flush & ~reset;
  assign issue     = if_valid & ~flush & ~hazard & ~dec_illegal;

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_rn       <= '0;
      ex_rm       <= '0;
      ex_ctrl     <= '0;
      ex_illegal  <= 1'b0;
      stall_count <= '0;
    end else begin
      if (issue) begin
        ex_valid <= 1'b1;
        ex_pc    <= if_pc;
        ex_op1   <= rf_read_1;
        ex_op2   <= rf_read_2;
        ex_imm   <= dec_imm;
        ex_rd    <= dec_dst;
        ex_rn    <= dec_src1;
        ex_rm    <= dec_src2;
        ex_ctrl  <= dec_ctrl;
      end else begin
        ex_valid <= 1'b0;
        ex_pc    <= '0;
        ex_op1   <= '0;
        ex_op2   <= '0;
        ex_imm   <= '0;
        ex_rd    <= '0;
        ex_rn    <= '0;
        ex_rm    <= '0;
        ex_ctrl  <= '0;
      end
      ex_illegal <= if_valid & ~flush & ~hazard & dec_illegal;
      if (stall_out && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end

  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_uncond     = ex_ctrl.uncond;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; register file returns Xi = i.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        flush;
  logic [4:0]  rf_add1, rf_add2;
  logic [63:0] rf_read_1, rf_read_2;
  logic        stall_out, ex_valid;
  logic [63:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rd, ex_rn, ex_rm;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_mem_to_reg, ex_branch, ex_uncond, ex_illegal;
  logic [31:0] stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  assign rf_read_1 = {59'd0, rf_add1};
  assign rf_read_2 = {59'd0, rf_add2};

  id_ex_stage dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .rf_add1(rf_add1), .rf_add2(rf_add2),
    .rf_read_1(rf_read_1), .rf_read_2(rf_read_2), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rn(ex_rn), .ex_rm(ex_rm),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_uncond(ex_uncond),
    .ex_illegal(ex_illegal), .stall_count(stall_count)
  );

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, rn, rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rn, rd);
    return {op, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm, input logic [4:0] rn, rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction

  // Drive IF/ID on the falling edge, away from the sampling posedge.
  task automatic put(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic fl);
    @(negedge clock);
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
  endtask

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    put(1'b1, enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3), 64'h40, 1'b0);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", stall_count); end
    checks++; if (ex_reg_write !== 1'b0 || ex_illegal !== 1'b0 || ex_op1 !== 64'd0) begin
      errors++; $display("FAIL reset_fields got rw=%0b ill=%0b op1=%0h want 0", ex_reg_write, ex_illegal, ex_op1); end
    reset = 1'b0;
    put(1'b0, 32'd0, 64'd0, 1'b0);
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall_out); end
    tick();
  endtask

  task automatic test_add;
    put(1'b1, enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3), 64'h100, 1'b0);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", ex_valid); end
    checks++; if (ex_op1 !== 64'd1 || ex_op2 !== 64'd2) begin errors++; $display("FAIL add_ops got %0h,%0h want 1,2", ex_op1, ex_op2); end
    checks++; if (ex_rd !== 5'd3 || ex_rn !== 5'd1 || ex_rm !== 5'd2) begin
      errors++; $display("FAIL add_regs got rd=%0d rn=%0d rm=%0d want 3,1,2", ex_rd, ex_rn, ex_rm); end
    checks++; if (ex_alu_op !== 4'b0010 || ex_reg_write !== 1'b1 || ex_alu_src !== 1'b0) begin
      errors++; $display("FAIL add_ctrl got op=%b rw=%0b src=%0b want 0010,1,0", ex_alu_op, ex_reg_write, ex_alu_src); end
    checks++; if (ex_pc !== 64'h100) begin errors++; $display("FAIL add_pc got %0h want 100", ex_pc); end
  endtask

  task automatic test_load_use;
    put(1'b1, enc_d(11'b11111000010, 9'h1F8, 5'd1, 5'd5), 64'h200, 1'b0);
    tick();
    checks++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL ldur_imm got %0h want fffffffffffffff8", ex_imm); end
    checks++; if (ex_mem_read !== 1'b1 || ex_mem_to_reg !== 1'b1 || ex_alu_src !== 1'b1 || ex_alu_op !== 4'b0010) begin
      errors++; $display("FAIL ldur_ctrl got mr=%0b m2r=%0b src=%0b op=%b want 1,1,1,0010", ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_alu_op); end
    put(1'b1, enc_r(11'b10001011000, 5'd2, 5'd5, 5'd6), 64'h204, 1'b0);
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", stall_out); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL lu_bubble got v=%0b rw=%0b want 0,0", ex_valid, ex_reg_write); end
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL lu_count got %0d want 1", stall_count); end
    @(negedge clock); #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lu_stall_once got %0b want 0", stall_out); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_op1 !== 64'd5 || ex_pc !== 64'h204) begin
      errors++; $display("FAIL lu_issue got v=%0b rd=%0d op1=%0h pc=%0h want 1,6,5,204", ex_valid, ex_rd, ex_op1, ex_pc); end
  endtask

  task automatic test_cbz_hazard;
    put(1'b1, enc_d(11'b11111000010, 9'd0, 5'd1, 5'd9), 64'h300, 1'b0);
    put(1'b1, {8'b10110100, 19'd3, 5'd9}, 64'h304, 1'b0);
    #1;
    checks++; if (stall_out !== 1'b1 || rf_add2 !== 5'd9) begin errors++; $display("FAIL cbz_stall got st=%0b a2=%0d want 1,9", stall_out, rf_add2); end
    tick(); tick();
    checks++; if (ex_branch !== 1'b1 || ex_alu_op !== 4'b0111 || ex_imm !== 64'd3 || ex_op2 !== 64'd9 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL cbz_ex got br=%0b op=%b imm=%0h op2=%0h rw=%0b want 1,0111,3,9,0", ex_branch, ex_alu_op, ex_imm, ex_op2, ex_reg_write); end
    checks++; if (stall_count !== 32'd2) begin errors++; $display("FAIL cbz_count got %0d want 2", stall_count); end
  endtask

  task automatic test_no_stall_cases;
    put(1'b1, enc_d(11'b11111000010, 9'd0, 5'd1, 5'd31), 64'h400, 1'b0);
    put(1'b1, enc_r(11'b10001011000, 5'd2, 5'd31, 5'd6), 64'h404, 1'b0);
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL x31_stall got %0b want 0", stall_out); end
    put(1'b1, enc_d(11'b11111000010, 9'd0, 5'd1, 5'd5), 64'h408, 1'b0);
    // ADDI X6,X7,#0x145: instr[20:16] = 5 but the field is immediate, not Rm.
    put(1'b1, enc_i(10'b1001000100, 12'h145, 5'd7, 5'd6), 64'h40C, 1'b0);
    #1;
    checks++; if (stall_out !== 1'b0 || rf_add2 !== 5'd5) begin errors++; $display("FAIL addi_stall got st=%0b a2=%0d want 0,5", stall_out, rf_add2); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_imm !== 64'h145 || ex_alu_src !== 1'b1 || ex_op1 !== 64'd7) begin
      errors++; $display("FAIL addi_ex got v=%0b imm=%0h src=%0b op1=%0h want 1,145,1,7", ex_valid, ex_imm, ex_alu_src, ex_op1); end
    checks++; if (stall_count !== 32'd2) begin errors++; $display("FAIL nostall_count got %0d want 2", stall_count); end
  endtask

  task automatic test_flush;
    put(1'b1, enc_d(11'b11111000010, 9'd0, 5'd1, 5'd5), 64'h500, 1'b0);
    put(1'b1, enc_r(11'b10001011000, 5'd2, 5'd5, 5'd6), 64'h504, 1'b1);
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", stall_out); end
    tick();
    checks++; if (ex_valid !== 1'b0 || stall_count !== 32'd2) begin
      errors++; $display("FAIL flush_ex got v=%0b cnt=%0d want 0,2", ex_valid, stall_count); end
  endtask

  task automatic test_illegal_and_b;
    put(1'b1, 32'hFFFF_FFFF, 64'h600, 1'b0);
    tick();
    checks++; if (ex_illegal !== 1'b1 || ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      errors++; $display("FAIL illegal got ill=%0b v=%0b rw=%0b mr=%0b want 1,0,0,0", ex_illegal, ex_valid, ex_reg_write, ex_mem_read); end
    put(1'b1, {6'b000101, 26'h3FF_FFFC}, 64'h604, 1'b0);
    tick();
    checks++; if (ex_illegal !== 1'b0 || ex_uncond !== 1'b1 || ex_valid !== 1'b1 || ex_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL b_ex got ill=%0b un=%0b v=%0b imm=%0h want 0,1,1,fffffffffffffffc", ex_illegal, ex_uncond, ex_valid, ex_imm); end
    put(1'b0, enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3), 64'h608, 1'b0);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL invalid_if got %0b want 0", ex_valid); end
  endtask

  task automatic test_reset_mid_stall;
    put(1'b1, enc_d(11'b11111000010, 9'd0, 5'd1, 5'd5), 64'h700, 1'b0);
    put(1'b1, enc_r(11'b10001011000, 5'd2, 5'd5, 5'd6), 64'h704, 1'b0);
    reset = 1'b1;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall_out); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== 5'd0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL rst_mid got v=%0b mr=%0b rd=%0d cnt=%0d want 0,0,0,0", ex_valid, ex_mem_read, ex_rd, stall_count); end
    @(negedge clock); reset = 1'b0; #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL post_rst_stall got %0b want 0", stall_out); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || stall_count !== 32'd0) begin
      errors++; $display("FAIL post_rst_issue got v=%0b rd=%0d cnt=%0d want 1,6,0", ex_valid, ex_rd, stall_count); end
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
    test_reset();
    test_add();
    test_load_use();
    test_cbz_hazard();
    test_no_stall_cases();
    test_flush();
    test_illegal_and_b();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
